fx2_stream_tx: RTL and testbench

Drains 16-bit words from the first-word-fall-through read port of `stream_fifo` into the FX2 slave-FIFO write interface (`USB_STREAM_SLWR_n`, `USB_STREAM_DATA`, `USB_STREAM_PKTEND_N`). It respects FX2 back-pressure, counts words per USB packet, and commits short packets with PKTEND after an idle timeout. This lets trigger data with low rates reach the host without waiting for a full 512-byte packet. It replaces the fixed `PKTEND_N = 1` tie-off at top level.

---
 rtl/fx2_stream_pkg.sv | 14 +
 rtl/fx2_pkt_timer.sv | 46 ++++
 rtl/fx2_stream_tx.sv | 95 +++++++++
 tb/tb_fx2_stream_tx.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fx2_stream_pkg.sv
// Shared types and defaults for the FX2 slave-FIFO stream writer.
// Imported by the top and the packet timer.
package fx2_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int FX2_PACKET_WORDS = 256;
  localparam int FX2_PKT_TIMEOUT  = 4096;

endpackage

// File: rtl/fx2_pkt_timer.sv
// Idle-cycle saturating counter and per-packet word counter.
// Flags when a short packet is due for commit.
module fx2_pkt_timer
  import fx2_stream_pkg::*;
#(
  parameter int PACKET_WORDS = FX2_PACKET_WORDS,
  parameter int TIMEOUT      = FX2_PKT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic idle_inc,
  input  logic idle_clr,
  input  logic pkt_inc,
  input  logic pkt_clr,
  output logic timeout_hit,
  output logic pkt_nonzero
);

  localparam int IW = $clog2(TIMEOUT);
  localparam int PW = $clog2(PACKET_WORDS);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

  logic [IW-1:0] idle_cnt;
  logic [PW-1:0] pkt_cnt;

  always_ff @(posedge clk) begin
    if (rst || idle_clr) begin
      idle_cnt <= '0;
    end else if (idle_inc && idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  // Power-of-two width, so a full packet wraps to zero on its own
  always_ff @(posedge clk) begin
    if (rst || pkt_clr) begin
      pkt_cnt <= '0;
    end else if (pkt_inc) begin
      pkt_cnt <= pkt_cnt + PW'(1);
    end
  end

  assign timeout_hit = (idle_cnt == IDLE_MAX);
  assign pkt_nonzero = (pkt_cnt != '0);

endmodule

// File: rtl/fx2_stream_tx.sv
// Drains an FWFT FIFO into the FX2 slave-FIFO write port.
// Short packets are committed with PKTEND after an idle timeout.
module fx2_stream_tx
  import fx2_stream_pkg::*;
#(
  parameter int PACKET_WORDS = FX2_PACKET_WORDS,
  parameter int TIMEOUT      = FX2_PKT_TIMEOUT
) (
  input  logic        STREAM_CLK,
  input  logic        STREAM_RST,
  input  logic        ENABLE,
  input  logic        STREAM_READY,
  input  logic        FIFO_EMPTY_IN,
  input  logic [15:0] FIFO_DATA,
  output logic        FIFO_READ_NEXT_OUT,
  output logic        STREAM_WRITE_N,
  output logic        STREAM_PKTEND_N,
  output logic [15:0] STREAM_DATA,
  output logic [31:0] WORD_COUNT
);

  state_t state;
  state_t state_nxt;
  logic   pop;
  logic   commit_go;
  logic   timeout_hit;
  logic   pkt_nonzero;
  logic   in_run;
  logic   in_commit;

  assign in_run    = (state == RUN);
  assign in_commit = (state == COMMIT);

  // No pop while reset is held, so no word is lost across reset
  assign pop = in_run & ~FIFO_EMPTY_IN & STREAM_READY & ~STREAM_RST;
  assign FIFO_READ_NEXT_OUT = pop;

  assign commit_go = in_run & ~pop & ENABLE & timeout_hit
                   & pkt_nonzero & STREAM_READY;

  fx2_pkt_timer #(
    .PACKET_WORDS(PACKET_WORDS),
    .TIMEOUT     (TIMEOUT)
  ) u_timer (
    .clk        (STREAM_CLK),
    .rst        (STREAM_RST),
    .idle_inc   (in_run & ~pop),
    .idle_clr   (pop | ~in_run),
    .pkt_inc    (pop),
    .pkt_clr    (in_commit),
    .timeout_hit(timeout_hit),
    .pkt_nonzero(pkt_nonzero)
  );

  always_ff @(posedge STREAM_CLK) begin
    if (STREAM_RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (ENABLE) state_nxt = RUN;
      end
      RUN: begin
        if (!pop && !ENABLE) state_nxt = IDLE;
        else if (commit_go) state_nxt = COMMIT;
      end
      COMMIT: state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Pin registers; PKTEND follows the COMMIT cycle, which never pops
  always_ff @(posedge STREAM_CLK) begin
    if (STREAM_RST) begin
      STREAM_WRITE_N  <= 1'b1;
      STREAM_PKTEND_N <= 1'b1;
      STREAM_DATA     <= '0;
      WORD_COUNT      <= '0;
    end else begin
      STREAM_WRITE_N  <= ~pop;
      STREAM_PKTEND_N <= ~in_commit;
      if (pop) begin
        STREAM_DATA <= FIFO_DATA;
        WORD_COUNT  <= WORD_COUNT + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_fx2_stream_tx.sv
// Directed bench for fx2_stream_tx with TIMEOUT = 16.
// An array-backed FWFT FIFO model feeds the DUT.
module tb_fx2_stream_tx;

  localparam int PW = 256;
  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        ready;
  logic        fifo_empty;
  logic [15:0] fifo_data;
  logic        rd_next;
  logic        wr_n;
  logic        pktend_n;
  logic [15:0] sdata;
  logic [31:0] wcount;

  logic [15:0] mem [0:1023];
  int          rd_ptr;
  int          wr_ptr;

  logic [15:0] got [0:2047];
  int          got_cyc [0:2047];
  int          got_n;
  int          pe_n;
  int          pe_cyc;
  int          last_wr;
  int          both_low;
  int          cyc;

  int          checks;
  int          passed;

  fx2_stream_tx #(
    .PACKET_WORDS(PW),
    .TIMEOUT     (TO)
  ) dut (
    .STREAM_CLK        (clk),
    .STREAM_RST        (rst),
    .ENABLE            (enable),
    .STREAM_READY      (ready),
    .FIFO_EMPTY_IN     (fifo_empty),
    .FIFO_DATA         (fifo_data),
    .FIFO_READ_NEXT_OUT(rd_next),
    .STREAM_WRITE_N    (wr_n),
    .STREAM_PKTEND_N   (pktend_n),
    .STREAM_DATA       (sdata),
    .WORD_COUNT        (wcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr[9:0]];

  always @(posedge clk) begin
    if (rd_next && rd_ptr != wr_ptr) rd_ptr <= rd_ptr + 1;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (wr_n === 1'b0) begin
      got[got_n]     = sdata;
      got_cyc[got_n] = cyc;
      got_n          = got_n + 1;
      last_wr        = cyc;
    end
    if (pktend_n === 1'b0) begin
      pe_n   = pe_n + 1;
      pe_cyc = cyc;
    end
    if (wr_n === 1'b0 && pktend_n === 1'b0) both_low = both_low + 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [15:0] w);
    mem[wr_ptr[9:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (wr_n !== 1'b1) $display("FAIL rst_wr_n got %b exp 1", wr_n);
    else passed++;
    checks++;
    if (pktend_n !== 1'b1) $display("FAIL rst_pktend got %b exp 1", pktend_n);
    else passed++;
    checks++;
    if (sdata !== 16'h0) $display("FAIL rst_data got %h exp 0000", sdata);
    else passed++;
    checks++;
    if (wcount !== 32'd0) $display("FAIL rst_wcount got %0d exp 0", wcount);
    else passed++;
    checks++;
    if (rd_next !== 1'b0) $display("FAIL rst_rd_next got %b exp 0", rd_next);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_burst();
    int base;
    int bad;
    base = got_n;
    pe_n = 0;
    for (int i = 0; i < 256; i++) push(16'(i));
    enable = 1'b1;
    for (int i = 0; i < 400 && got_n < base + 256; i++) tick();
    repeat (5) tick();
    checks++;
    if (got_n - base !== 256)
      $display("FAIL burst_count got %0d exp 256", got_n - base);
    else passed++;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (got[base + i] !== 16'(i)) bad++;
    end
    checks++;
    if (bad !== 0) $display("FAIL burst_order got %0d bad exp 0", bad);
    else passed++;
    checks++;
    if (got_cyc[base + 255] - got_cyc[base] !== 255)
      $display("FAIL burst_span got %0d exp 255",
               got_cyc[base + 255] - got_cyc[base]);
    else passed++;
    checks++;
    if (pe_n !== 0) $display("FAIL burst_pktend got %0d exp 0", pe_n);
    else passed++;
    checks++;
    if (wcount !== 32'd256) $display("FAIL burst_wcount got %0d exp 256", wcount);
    else passed++;
    checks++;
    if (dut.u_timer.pkt_cnt !== 8'd0)
      $display("FAIL burst_pkt_cnt got %0d exp 0", dut.u_timer.pkt_cnt);
    else passed++;
  endtask

  task automatic test_short_packet();
    int base;
    base = got_n;
    pe_n = 0;
    for (int i = 0; i < 5; i++) push(16'hA000 + 16'(i));
    repeat (40) tick();
    checks++;
    if (got_n - base !== 5 || got[base + 4] !== 16'hA004)
      $display("FAIL short_words got %0d exp 5", got_n - base);
    else passed++;
    checks++;
    if (pe_n !== 1) $display("FAIL short_pktend_n got %0d exp 1", pe_n);
    else passed++;
    checks++;
    if (pe_cyc - last_wr !== TO + 1)
      $display("FAIL short_gap got %0d exp %0d", pe_cyc - last_wr, TO + 1);
    else passed++;
    checks++;
    if (dut.u_timer.pkt_cnt !== 8'd0)
      $display("FAIL short_pkt_cnt got %0d exp 0", dut.u_timer.pkt_cnt);
    else passed++;
    checks++;
    if (wcount !== 32'd261) $display("FAIL short_wcount got %0d exp 261", wcount);
    else passed++;
  endtask

  task automatic test_back_pressure();
    int base;
    int r0;
    int s0;
    int bad;
    logic popped;
    base = got_n;
    popped = 1'b0;
    for (int i = 0; i < 20; i++) push(16'hB000 + 16'(i));
    repeat (5) tick();
    ready = 1'b0;
    r0 = rd_ptr;
    tick();
    s0 = got_n;
    for (int i = 0; i < 9; i++) begin
      if (rd_next !== 1'b0) popped = 1'b1;
      tick();
    end
    checks++;
    if (rd_ptr !== r0 || popped)
      $display("FAIL bp_pops got %0d exp %0d", rd_ptr, r0);
    else passed++;
    checks++;
    if (got_n !== s0) $display("FAIL bp_strobes got %0d exp %0d", got_n, s0);
    else passed++;
    ready = 1'b1;
    repeat (60) tick();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (got[base + i] !== 16'hB000 + 16'(i)) bad++;
    end
    checks++;
    if (got_n - base !== 20 || bad !== 0)
      $display("FAIL bp_data got %0d words %0d bad exp 20 words 0 bad",
               got_n - base, bad);
    else passed++;
    checks++;
    if (wcount !== 32'd281) $display("FAIL bp_wcount got %0d exp 281", wcount);
    else passed++;
  endtask

  task automatic test_race();
    int base;
    base = got_n;
    pe_n = 0;
    push(16'hC001);
    repeat (16) tick();
    push(16'hC002);
    repeat (12) tick();
    checks++;
    if (pe_n !== 0 || got_n - base !== 2)
      $display("FAIL race_no_pktend got %0d pktend %0d words exp 0 pktend 2 words",
               pe_n, got_n - base);
    else passed++;
    repeat (30) tick();
    checks++;
    if (pe_n !== 1 || pe_cyc - last_wr !== TO + 1)
      $display("FAIL race_restart got %0d pktend gap %0d exp 1 pktend gap %0d",
               pe_n, pe_cyc - last_wr, TO + 1);
    else passed++;
  endtask

  task automatic test_empty_idle();
    pe_n = 0;
    repeat (10 * TO) tick();
    checks++;
    if (pe_n !== 0) $display("FAIL empty_idle got %0d exp 0", pe_n);
    else passed++;
  endtask

  task automatic test_disable();
    pe_n = 0;
    for (int i = 0; i < 3; i++) push(16'hD000 + 16'(i));
    repeat (5) tick();
    enable = 1'b0;
    repeat (60) tick();
    checks++;
    if (pe_n !== 0) $display("FAIL dis_pktend got %0d exp 0", pe_n);
    else passed++;
    checks++;
    if (dut.u_timer.pkt_cnt !== 8'd3)
      $display("FAIL dis_pkt_cnt got %0d exp 3", dut.u_timer.pkt_cnt);
    else passed++;
    enable = 1'b1;
    push(16'hD003);
    push(16'hD004);
    repeat (40) tick();
    checks++;
    if (pe_n !== 1 || pe_cyc - last_wr !== TO + 1)
      $display("FAIL dis_resume got %0d pktend gap %0d exp 1 pktend gap %0d",
               pe_n, pe_cyc - last_wr, TO + 1);
    else passed++;
    checks++;
    if (wcount !== 32'd288) $display("FAIL dis_wcount got %0d exp 288", wcount);
    else passed++;
  endtask

  task automatic test_reset_mid();
    pe_n = 0;
    for (int i = 0; i < 3; i++) push(16'hE000 + 16'(i));
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (wr_n !== 1'b1 || pktend_n !== 1'b1 || sdata !== 16'h0)
      $display("FAIL rmid_pins got %b %b %h exp 1 1 0000", wr_n, pktend_n, sdata);
    else passed++;
    checks++;
    if (wcount !== 32'd0) $display("FAIL rmid_wcount got %0d exp 0", wcount);
    else passed++;
    checks++;
    if (dut.u_timer.pkt_cnt !== 8'd0)
      $display("FAIL rmid_pkt_cnt got %0d exp 0", dut.u_timer.pkt_cnt);
    else passed++;
    rst = 1'b0;
    repeat (50) tick();
    checks++;
    if (pe_n !== 0) $display("FAIL rmid_pktend got %0d exp 0", pe_n);
    else passed++;
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    ready    = 1'b1;
    rd_ptr   = 0;
    wr_ptr   = 0;
    got_n    = 0;
    pe_n     = 0;
    pe_cyc   = 0;
    last_wr  = 0;
    both_low = 0;
    cyc      = 0;
    checks   = 0;
    passed   = 0;
    test_reset();
    test_burst();
    test_short_packet();
    test_back_pressure();
    test_race();
    test_empty_idle();
    test_disable();
    test_reset_mid();
    checks++;
    if (both_low !== 0)
      $display("FAIL slwr_pktend_overlap got %0d exp 0", both_low);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
